md_unit: RTL

//  Parametrised multiply/divide unit with HI/LO registers for the E stage of the
//  5-stage MIPS pipeline. Executes mult/multu/div/divu over a configurable number
//  of cycles and services mthi/mtlo writes.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_divider.sv | 45 ++++
 rtl/md_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings and sizing helpers for the E-stage multiply/divide unit.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // Counter must hold the larger of the two latencies.
   function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
      int longest;
      longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return $clog2(longest + 1);
   endfunction

   localparam int MD_CNT_W = md_cnt_width(5, 10);

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero and the
// remainder follows the dividend's sign; a zero divisor is flagged, not computed.
module md_divider
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

   logic             neg_n_s;
   logic             neg_d_s;
   logic [WIDTH-1:0] mag_n_s;
   logic [WIDTH-1:0] mag_d_s;
   logic [WIDTH-1:0] q_mag_s;
   logic [WIDTH-1:0] r_mag_s;

   // Magnitude divide then restore signs; most-negative / -1 wraps back to itself.
   always_comb begin
      neg_n_s   = is_signed & dividend[WIDTH-1];
      neg_d_s   = is_signed & divisor[WIDTH-1];
      div_zero  = (divisor == ZERO);
      mag_n_s   = neg_n_s ? (~dividend + ONE) : dividend;
      if (div_zero) begin
         mag_d_s = ONE;
      end else if (neg_d_s) begin
         mag_d_s = ~divisor + ONE;
      end else begin
         mag_d_s = divisor;
      end
      q_mag_s   = mag_n_s / mag_d_s;
      r_mag_s   = mag_n_s % mag_d_s;
      quotient  = (neg_n_s ^ neg_d_s) ? (~q_mag_s + ONE) : q_mag_s;
      remainder = neg_n_s ? (~r_mag_s + ONE) : r_mag_s;
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the pipeline E stage.
// Operands are latched at start; the result is written when the down-counter expires.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

   md_state_e              state_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [WIDTH-1:0]       a_r;
   logic [WIDTH-1:0]       b_r;
   logic                   is_div_r;
   logic                   is_signed_r;
   logic [WIDTH-1:0]       hi_r;
   logic [WIDTH-1:0]       lo_r;
   logic                   busy_r;
   logic                   done_r;

   logic [2*WIDTH-1:0]     ext_a_s;
   logic [2*WIDTH-1:0]     ext_b_s;
   logic [2*WIDTH-1:0]     prod_s;
   logic [WIDTH-1:0]       quot_s;
   logic [WIDTH-1:0]       rem_s;
   logic                   div_zero_s;
   logic [WIDTH-1:0]       res_hi_s;
   logic [WIDTH-1:0]       res_lo_s;
   logic                   res_we_s;

   md_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .dividend  (a_r),
      .divisor   (b_r),
      .is_signed (is_signed_r),
      .quotient  (quot_s),
      .remainder (rem_s),
      .div_zero  (div_zero_s)
   );

   // Result select; the low 2*WIDTH bits of the extended product are exact for both signednesses.
   always_comb begin
      if (is_signed_r) begin
         ext_a_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
         ext_b_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
      end else begin
         ext_a_s = {{WIDTH{1'b0}}, a_r};
         ext_b_s = {{WIDTH{1'b0}}, b_r};
      end
      prod_s = ext_a_s * ext_b_s;
      if (is_div_r) begin
         res_hi_s = rem_s;
         res_lo_s = quot_s;
         res_we_s = ~div_zero_s;
      end else begin
         res_hi_s = prod_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
         res_we_s = 1'b1;
      end
   end

   // Sequencer: accepts ops in IDLE, counts down in RUN, commits HI/LO on expiry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= MD_IDLE;
         cnt_r       <= CNT_W'(0);
         a_r         <= WIDTH'(0);
         b_r         <= WIDTH'(0);
         is_div_r    <= 1'b0;
         is_signed_r <= 1'b0;
         hi_r        <= WIDTH'(0);
         lo_r        <= WIDTH'(0);
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            MD_IDLE: begin
               if (start) begin
                  case (op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        a_r         <= a;
                        b_r         <= b;
                        is_div_r    <= (op == MD_DIV) || (op == MD_DIVU);
                        is_signed_r <= (op == MD_MULT) || (op == MD_DIV);
                        cnt_r       <= ((op == MD_DIV) || (op == MD_DIVU)) ?
                                       CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_r     <= MD_RUN;
                        busy_r      <= 1'b1;
                     end
                     MD_MTHI: hi_r <= a;
                     MD_MTLO: lo_r <= a;
                     default: ;
                  endcase
               end
            end
            MD_RUN: begin
               if (cnt_r == CNT_W'(1)) begin
                  if (res_we_s) begin
                     hi_r <= res_hi_s;
                     lo_r <= res_lo_s;
                  end
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  cnt_r   <= CNT_W'(0);
                  state_r <= MD_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r <= MD_IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= CNT_W'(0);
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule
